// File: rtl/hpgp_turbo_pkg.sv
`default_nettype none
// Shared types, PB sizes and permutation constants for the HomePlug GP turbo (de)interleaver buffer.
package hpgp_turbo_pkg;

   typedef logic [11:0] addr_t;
   typedef logic [1:0]  sym_t;

   localparam addr_t N_PB16  = 12'd64;
   localparam addr_t N_PB136 = 12'd544;
   localparam addr_t N_PB520 = 12'd2080;

   localparam int P_PB16     = 13;
   localparam int PINV_PB16  = 5;
   localparam int P_PB136    = 31;
   localparam int PINV_PB136 = 351;
   localparam int P_PB520    = 47;
   localparam int PINV_PB520 = 1903;

   localparam addr_t STEP_PB16_INT   = 12'd52;
   localparam addr_t STEP_PB16_DINT  = 12'd20;
   localparam addr_t STEP_PB136_INT  = 12'd124;
   localparam addr_t STEP_PB136_DINT = 12'd316;
   localparam addr_t STEP_PB520_INT  = 12'd188;
   localparam addr_t STEP_PB520_DINT = 12'd1372;

   typedef struct packed {
      addr_t       n;
      addr_t       step;
      addr_t [3:0] init;
   } perm_cfg_t;

   // Only ever called with constant m/n, so the products fold away.
   function automatic perm_cfg_t make_cfg(input int m, input int n, input addr_t step);
      perm_cfg_t cfg;
      cfg.n    = addr_t'(n);
      cfg.step = step;
      for (int j = 0; j < 4; j++) begin
         cfg.init[j] = addr_t'((j * m) % n);
      end
      return cfg;
   endfunction

   function automatic perm_cfg_t lookup_cfg(input addr_t len, input logic itl);
      perm_cfg_t cfg;
      case (len)
         N_PB16:  cfg = itl ? make_cfg(P_PB16, 64, STEP_PB16_INT)
                            : make_cfg(PINV_PB16, 64, STEP_PB16_DINT);
         N_PB136: cfg = itl ? make_cfg(P_PB136, 544, STEP_PB136_INT)
                            : make_cfg(PINV_PB136, 544, STEP_PB136_DINT);
         N_PB520: cfg = itl ? make_cfg(P_PB520, 2080, STEP_PB520_INT)
                            : make_cfg(PINV_PB520, 2080, STEP_PB520_DINT);
         default: begin
            cfg.n    = len;
            cfg.step = 12'd4;
            cfg.init = {12'd3, 12'd2, 12'd1, 12'd0};
         end
      endcase
      return cfg;
   endfunction

   // a, s < n, so one conditional subtract keeps the result below n.
   function automatic addr_t wrap_add(input addr_t a, input addr_t s, input addr_t n);
      logic [12:0] sum;
      sum = {1'b0, a} + {1'b0, s};
      return (sum >= {1'b0, n}) ? addr_t'(sum - {1'b0, n}) : addr_t'(sum);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hpgp_itl_addr_gen.sv
`default_nettype none
// Control FSM, group counter and four incremental lane address registers.
// Addresses are relative to the PB base; the start cycle uses the fresh config directly.
module hpgp_itl_addr_gen
   import hpgp_turbo_pkg::*;
(
   input  logic        clk,
   input  logic        n_rst,
   input  logic        start,
   input  logic        din_vld,
   input  addr_t       pb_len,
   input  logic        mod_int_dint,
   output addr_t [3:0] rel_addr,
   output logic        issue
);

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t      state;
   addr_t       n_q;
   addr_t       step_q;
   addr_t [3:0] lane_q;
   logic  [9:0] grp_q;

   perm_cfg_t   new_cfg;
   addr_t       cur_n;
   addr_t       cur_step;
   addr_t [3:0] cur_lane;
   logic  [9:0] cur_grp;
   logic  [9:0] last_grp;

   assign new_cfg  = lookup_cfg(pb_len, mod_int_dint);
   assign cur_n    = start ? new_cfg.n    : n_q;
   assign cur_step = start ? new_cfg.step : step_q;
   assign cur_lane = start ? new_cfg.init : lane_q;
   assign cur_grp  = start ? '0 : grp_q;
   assign last_grp = cur_n[11:2] - 10'd1;

   assign issue    = din_vld & (start | (state == RUN));
   assign rel_addr = cur_lane;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state  <= IDLE;
         n_q    <= '0;
         step_q <= '0;
         lane_q <= '0;
         grp_q  <= '0;
      end else if (issue) begin
         n_q    <= cur_n;
         step_q <= cur_step;
         grp_q  <= cur_grp + 10'd1;
         for (int j = 0; j < 4; j++) begin
            lane_q[j] <= wrap_add(cur_lane[j], cur_step, cur_n);
         end
         state  <= (cur_grp == last_grp) ? IDLE : RUN;
      end else if (start) begin
         n_q    <= cur_n;
         step_q <= cur_step;
         lane_q <= cur_lane;
         grp_q  <= '0;
         state  <= RUN;
      end
   end

endmodule
`default_nettype wire

// File: rtl/hpgp_turbo_rx.sv
`default_nettype none
// Receive-side HomePlug GP turbo (de)interleaver buffer: 4096x2-bit symbol memory
// read out four permuted symbols per cycle for one PB after each start pulse.
module hpgp_turbo_rx
   import hpgp_turbo_pkg::*;
(
   input  logic  clk,
   input  logic  n_rst,
   input  sym_t  wdata,
   input  addr_t waddr,
   input  logic  wen,
   input  addr_t pb_offset,
   input  addr_t pb_len,
   input  logic  mod_int_dint,
   input  logic  start,
   input  logic  din_vld,
   output sym_t  rdata0,
   output sym_t  rdata1,
   output sym_t  rdata2,
   output sym_t  rdata3,
   output logic  dout_vld
);

   sym_t        mem [4096];
   addr_t       base_q;
   addr_t       base;
   addr_t [3:0] rel_addr;
   addr_t       rd_addr [4];
   logic        issue;
   sym_t  [3:0] rd_q;

   hpgp_itl_addr_gen u_addr_gen (
      .clk          (clk),
      .n_rst        (n_rst),
      .start        (start),
      .din_vld      (din_vld),
      .pb_len       (pb_len),
      .mod_int_dint (mod_int_dint),
      .rel_addr     (rel_addr),
      .issue        (issue)
   );

   assign base = start ? pb_offset : base_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         base_q <= '0;
      end else if (start) begin
         base_q <= pb_offset;
      end
   end

   // 12-bit adders wrap modulo the memory size.
   generate
      for (genvar j = 0; j < 4; j++) begin : g_lane
         assign rd_addr[j] = base + rel_addr[j];
      end
   endgenerate

   // Memory holds no reset; a same-cycle read of a written address sees the old symbol.
   always_ff @(posedge clk) begin
      if (wen) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rd_q     <= '0;
         dout_vld <= 1'b0;
      end else begin
         dout_vld <= issue;
         if (issue) begin
            for (int j = 0; j < 4; j++) begin
               rd_q[j] <= mem[rd_addr[j]];
            end
         end
      end
   end

   assign rdata0 = rd_q[0];
   assign rdata1 = rd_q[1];
   assign rdata2 = rd_q[2];
   assign rdata3 = rd_q[3];

endmodule
`default_nettype wire

// File: tb/tb_hpgp_turbo_rx.sv
`default_nettype none
// Self-checking bench for hpgp_turbo_rx: directed steps plus randomised PBs, each output
// compared with mem[(offset + M*i mod N) mod 4096] from a scoreboard memory image.
module tb_hpgp_turbo_rx;

   logic        clk = 1'b0;
   logic        n_rst;
   logic [1:0]  wdata;
   logic [11:0] waddr;
   logic        wen;
   logic [11:0] pb_offset;
   logic [11:0] pb_len;
   logic        mod_int_dint;
   logic        start;
   logic        din_vld;
   logic [1:0]  rdata0, rdata1, rdata2, rdata3;
   logic        dout_vld;

   always #5 clk = ~clk;

   hpgp_turbo_rx dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .wdata        (wdata),
      .waddr        (waddr),
      .wen          (wen),
      .pb_offset    (pb_offset),
      .pb_len       (pb_len),
      .mod_int_dint (mod_int_dint),
      .start        (start),
      .din_vld      (din_vld),
      .rdata0       (rdata0),
      .rdata1       (rdata1),
      .rdata2       (rdata2),
      .rdata3       (rdata3),
      .dout_vld     (dout_vld)
   );

   logic [1:0] refmem [4096];
   logic [1:0] cap    [2080];
   logic [1:0] orig   [64];
   logic [1:0] exp_rd [4];
   bit         exp_vld;
   bit         m_act;
   int         m_grp, m_n, m_m, m_off, cap_grp;
   int         total = 0;
   int         bad   = 0;
   int         vld_count;
   int         off1, off2;
   logic [1:0] old_sym, new_sym;

   function automatic int mult_for(input int n, input bit itl);
      case (n)
         64:      return itl ? 13 : 5;
         544:     return itl ? 31 : 351;
         2080:    return itl ? 47 : 1903;
         default: return 1;
      endcase
   endfunction

   function automatic logic [1:0] pat(input int a);
      logic [11:0] x;
      x = a[11:0];
      return x[3:2] ^ x[1:0];
   endfunction

   function automatic logic [1:0] rd(input int j);
      case (j)
         0:       return rdata0;
         1:       return rdata1;
         2:       return rdata2;
         default: return rdata3;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the reference model, then check all outputs.
   task automatic step(input bit st, input bit dv, input int off = 0, input int len = 0,
                       input bit itl = 1'b0, input bit we = 1'b0, input int wa = 0,
                       input logic [1:0] wd = 2'b00);
      start        = st;
      din_vld      = dv;
      pb_offset    = off[11:0];
      pb_len       = len[11:0];
      mod_int_dint = itl;
      wen          = we;
      waddr        = wa[11:0];
      wdata        = wd;
      if (st) begin
         m_act = 1'b1;
         m_grp = 0;
         m_n   = len;
         m_m   = mult_for(len, itl);
         m_off = off;
      end
      exp_vld = m_act && dv;
      if (exp_vld) begin
         cap_grp = m_grp;
         for (int j = 0; j < 4; j++) begin
            exp_rd[j] = refmem[(m_off + (m_m * (4 * m_grp + j)) % m_n) % 4096];
         end
         m_grp++;
         if (m_grp == m_n / 4) m_act = 1'b0;
      end
      if (we) refmem[wa % 4096] = wd;
      @(posedge clk);
      #1;
      chk("dout_vld", dout_vld, exp_vld);
      if (dout_vld) vld_count++;
      for (int j = 0; j < 4; j++) begin
         if (dout_vld && exp_vld) cap[4 * cap_grp + j] = rd(j);
         chk($sformatf("rdata%0d", j), rd(j), exp_rd[j]);
      end
   endtask

   initial begin
      n_rst = 1'b0; start = 1'b0; din_vld = 1'b0; wen = 1'b0;
      wdata = '0; waddr = '0; pb_offset = '0; pb_len = '0; mod_int_dint = 1'b0;
      m_act = 1'b0; exp_vld = 1'b0; vld_count = 0; cap_grp = 0;
      for (int j = 0; j < 4; j++) exp_rd[j] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_dout_vld", dout_vld, 0);
      for (int j = 0; j < 4; j++) chk("reset_rdata", rd(j), 0);
      n_rst = 1'b1;

      for (int a = 0; a < 4096; a++) step(0, 0, 0, 0, 0, 1, a, pat(a));

      // N=64 interleave at offset 0
      vld_count = 0;
      step(1, 1, 0, 64, 1);
      chk("pb16_int_g0_l0", rdata0, pat(0));
      chk("pb16_int_g0_l1", rdata1, pat(13));
      chk("pb16_int_g0_l2", rdata2, pat(26));
      chk("pb16_int_g0_l3", rdata3, pat(39));
      step(0, 1);
      chk("pb16_int_g1_l0", rdata0, pat(52));
      chk("pb16_int_g1_l1", rdata1, pat(1));
      chk("pb16_int_g1_l2", rdata2, pat(14));
      chk("pb16_int_g1_l3", rdata3, pat(27));
      repeat (14) step(0, 1);
      repeat (3) step(0, 1);
      chk("pb16_int_groups", vld_count, 16);

      // N=64 deinterleave
      step(1, 1, 0, 64, 0);
      chk("pb16_dint_g0_l1", rdata1, pat(5));
      chk("pb16_dint_g0_l2", rdata2, pat(10));
      chk("pb16_dint_g0_l3", rdata3, pat(15));
      repeat (15) step(0, 1);

      // Random memory image for the remaining scenarios
      for (int a = 0; a < 4096; a++) step(0, 0, 0, 0, 0, 1, a, 2'($urandom));

      // Interleave then deinterleave restores the original order
      for (int i = 0; i < 64; i++) orig[i] = refmem[i];
      step(1, 1, 0, 64, 1);
      repeat (15) step(0, 1);
      for (int i = 0; i < 64; i++) step(0, 0, 0, 0, 0, 1, 256 + i, cap[i]);
      step(1, 1, 256, 64, 0);
      repeat (15) step(0, 1);
      for (int i = 0; i < 64; i++) chk($sformatf("roundtrip_%0d", i), cap[i], orig[i]);

      // N=544 interleave with a 5-cycle din_vld gap
      vld_count = 0;
      off1 = $urandom_range(0, 4095);
      step(1, 1, off1, 544, 1);
      step(0, 1);
      chk("pb136_g1_l0", rdata0, refmem[(off1 + 124) % 4096]);
      chk("pb136_g1_l1", rdata1, refmem[(off1 + 155) % 4096]);
      chk("pb136_g1_l2", rdata2, refmem[(off1 + 186) % 4096]);
      chk("pb136_g1_l3", rdata3, refmem[(off1 + 217) % 4096]);
      repeat (58) step(0, 1);
      repeat (5) step(0, 0);
      repeat (76) step(0, 1);
      repeat (2) step(0, 1);
      chk("pb136_groups", vld_count, 136);

      // Offset wrap past the top of memory
      step(1, 1, 12'hFF0, 64, 1);
      chk("wrap_l1", rdata1, refmem[12'hFFD]);
      chk("wrap_l3", rdata3, refmem[12'h017]);
      repeat (15) step(0, 1);

      // Abort at group 50 with a new config
      off1 = $urandom_range(0, 4095);
      off2 = $urandom_range(0, 4095);
      step(1, 1, off1, 544, 0);
      repeat (49) step(0, 1);
      step(1, 1, off2, 2080, 1);
      chk("abort_g0_l0", rdata0, refmem[off2]);
      chk("abort_g0_l1", rdata1, refmem[(off2 + 47) % 4096]);
      repeat (30) step(0, bit'($urandom_range(0, 1)));
      vld_count = 0;
      step(1, 1, $urandom_range(0, 4095), 128, 1);
      for (int lim = 0; lim < 200 && m_act; lim++) step(0, bit'($urandom_range(0, 1)));
      repeat (2) step(0, 1);
      chk("identity_groups", vld_count, 32);

      // Write collision: same-cycle read returns the old symbol
      old_sym = refmem[12'h200];
      new_sym = ~old_sym;
      step(1, 1, 12'h200, 64, 1, 1, 12'h200, new_sym);
      chk("collide_old", rdata0, old_sym);
      repeat (15) step(0, 1);
      step(1, 1, 12'h200, 64, 1);
      chk("collide_new", rdata0, new_sym);
      repeat (15) step(0, 1);

      // Reset mid-PB
      step(1, 1, $urandom_range(0, 4095), 2080, 1);
      repeat (20) step(0, 1);
      #2 n_rst = 1'b0;
      #1;
      m_act = 1'b0;
      exp_vld = 1'b0;
      for (int j = 0; j < 4; j++) exp_rd[j] = '0;
      chk("rst_mid_dout_vld", dout_vld, 0);
      for (int j = 0; j < 4; j++) chk("rst_mid_rdata", rd(j), 0);
      #1 n_rst = 1'b1;
      start = 1'b0;
      din_vld = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_idle_dout_vld", dout_vld, 0);
      repeat (4) step(0, 1);

      // Randomised PBs with random flow control and background writes
      for (int r = 0; r < 5; r++) begin
         int len;
         case ($urandom_range(0, 3))
            0:       len = 64;
            1:       len = 544;
            2:       len = 2080;
            default: len = 4 * $urandom_range(1, 200);
         endcase
         vld_count = 0;
         step(1, 1, $urandom_range(0, 4095), len, bit'($urandom_range(0, 1)));
         for (int lim = 0; lim < 3000 && m_act; lim++) begin
            step(0, $urandom_range(0, 3) != 0, 0, 0, 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 4095), 2'($urandom));
         end
         repeat (2) step(0, 1);
         chk($sformatf("rand_groups_%0d", r), vld_count, len / 4);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
